// File: rtl/video_mode_detect.sv
// -----------------------------------------------------------------------------
// video_mode_detect
//   Measures Dreamcast input video timing. It counts hsync falling edges
//   between successive vsync falling edges and classifies each frame or field
//   as 480p (>= LINE_THRESHOLD lines) or 480i. The mode output changes only
//   after STABLE_FRAMES consecutive agreeing measurements. If no vsync arrives
//   within LINE_MAX lines, the block treats the signal as lost and re-enters
//   SEARCH.
//
// Ports
//   clock           in   DC pixel clock; all logic on the rising edge
//   reset_n         in   asynchronous active-low reset
//   hsync_n         in   raw hsync, active low, asynchronous to clock
//   vsync_n         in   raw vsync, active low, asynchronous to clock
//   _480p_active_n  out  0 = 480p active, 1 = 480i active
//   locked          out  last STABLE_FRAMES measurements agree with the mode
//   mode_changed    out  one-cycle pulse when _480p_active_n toggles
//   line_count      out  line count of the last completed frame or field
//   field_odd       out  only with VMD_FIELD_PARITY_EN defined: odd-length
//                        480i field indicator
//
// Configuration macro: VMD_FIELD_PARITY_EN (adds the field_odd output)
// -----------------------------------------------------------------------------
module video_mode_detect #(
  parameter int LINE_THRESHOLD = 400,
  parameter int STABLE_FRAMES  = 3,
  parameter int LINE_MAX       = 2047,
  parameter int CNT_W          = 11
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             hsync_n,
  input  logic             vsync_n,
  output logic             _480p_active_n,
  output logic             locked,
  output logic             mode_changed,
  output logic [CNT_W-1:0] line_count
`ifdef VMD_FIELD_PARITY_EN
  ,
  output logic             field_odd
`endif
);

  localparam logic [CNT_W-1:0] LMAX_C   = CNT_W'(LINE_MAX);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(LINE_THRESHOLD);
  localparam logic [2:0]       STABLE_C = 3'(STABLE_FRAMES);

  typedef enum logic [0:0] {
    ST_SEARCH  = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t           state_q, state_d;

  // Synchronizers: meta -> sync -> delay, one chain per sync input.
  logic             hs_meta_q, hs_meta_d, hs_sync_q, hs_sync_d, hs_dly_q, hs_dly_d;
  logic             vs_meta_q, vs_meta_d, vs_sync_q, vs_sync_d, vs_dly_q, vs_dly_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] line_count_q, line_count_d;
  logic             cand_q, cand_d;          // 1 = candidate mode is progressive
  logic [2:0]       agree_q, agree_d;
  logic             active_n_q, active_n_d;
  logic             locked_q, locked_d;
  logic             mode_changed_q, mode_changed_d;
  logic             field_odd_q, field_odd_d;

  logic             hs_edge_s, vs_edge_s, prog_s;

  assign hs_edge_s = hs_dly_q & ~hs_sync_q;
  assign vs_edge_s = vs_dly_q & ~vs_sync_q;
  assign prog_s    = (cnt_q >= THRESH_C);

  // Synchronizer shift for both sync inputs.
  always_comb begin
    hs_meta_d = hsync_n;
    hs_sync_d = hs_meta_q;
    hs_dly_d  = hs_sync_q;
    vs_meta_d = vsync_n;
    vs_sync_d = vs_meta_q;
    vs_dly_d  = vs_sync_q;
  end

  // State register plus all datapath flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_SEARCH;
      hs_meta_q      <= 1'b1;
      hs_sync_q      <= 1'b1;
      hs_dly_q       <= 1'b1;
      vs_meta_q      <= 1'b1;
      vs_sync_q      <= 1'b1;
      vs_dly_q       <= 1'b1;
      cnt_q          <= '0;
      line_count_q   <= '0;
      cand_q         <= 1'b0;
      agree_q        <= 3'd0;
      active_n_q     <= 1'b1;
      locked_q       <= 1'b0;
      mode_changed_q <= 1'b0;
      field_odd_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      hs_meta_q      <= hs_meta_d;
      hs_sync_q      <= hs_sync_d;
      hs_dly_q       <= hs_dly_d;
      vs_meta_q      <= vs_meta_d;
      vs_sync_q      <= vs_sync_d;
      vs_dly_q       <= vs_dly_d;
      cnt_q          <= cnt_d;
      line_count_q   <= line_count_d;
      cand_q         <= cand_d;
      agree_q        <= agree_d;
      active_n_q     <= active_n_d;
      locked_q       <= locked_d;
      mode_changed_q <= mode_changed_d;
      field_odd_q    <= field_odd_d;
    end
  end

  // Next-state logic: a vsync leaves SEARCH; a saturated counter returns there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (vs_edge_s) state_d = ST_MEASURE;
        else           state_d = ST_SEARCH;
      end
      ST_MEASURE: begin
        if (!vs_edge_s && (cnt_q == LMAX_C)) state_d = ST_SEARCH;
        else                                 state_d = ST_MEASURE;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Output/datapath logic: line counting, classification and hysteresis.
  always_comb begin
    cnt_d          = cnt_q;
    line_count_d   = line_count_q;
    cand_d         = cand_q;
    agree_d        = agree_q;
    active_n_d     = active_n_q;
    locked_d       = locked_q;
    mode_changed_d = 1'b0;
    field_odd_d    = field_odd_q;
    case (state_q)
      ST_SEARCH: begin
        locked_d = 1'b0;
        if (vs_edge_s) cnt_d = '0;
        else           cnt_d = cnt_q;
      end
      ST_MEASURE: begin
        if (vs_edge_s) begin
          line_count_d = cnt_q;
          // A coincident hsync belongs to the new frame, so it seeds the count.
          if (hs_edge_s) cnt_d = CNT_W'(1);
          else           cnt_d = '0;
          if (prog_s) field_odd_d = 1'b0;
          else        field_odd_d = cnt_q[0];
          if (prog_s == cand_q) begin
            if (agree_q < STABLE_C) agree_d = agree_q + 3'd1;
            else                    agree_d = agree_q;
          end else begin
            cand_d  = prog_s;
            agree_d = 3'd1;
          end
          // active_n is the inverse of the progressive flag, so equal values
          // mean the candidate differs from the current mode.
          if ((agree_d == STABLE_C) && (cand_d == active_n_q)) begin
            active_n_d     = ~cand_d;
            mode_changed_d = 1'b1;
          end else begin
            active_n_d     = active_n_q;
            mode_changed_d = 1'b0;
          end
          locked_d = (agree_d == STABLE_C) && (cand_d != active_n_d);
        end else if (cnt_q == LMAX_C) begin
          // Signal lost: hold the counter, drop lock and restart hysteresis.
          cnt_d    = cnt_q;
          locked_d = 1'b0;
          agree_d  = 3'd0;
        end else if (hs_edge_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d    = '0;
        locked_d = 1'b0;
      end
    endcase
  end

  assign _480p_active_n = active_n_q;
  assign locked         = locked_q;
  assign mode_changed   = mode_changed_q;
  assign line_count     = line_count_q;

`ifdef VMD_FIELD_PARITY_EN
  assign field_odd = field_odd_q;
`else
  logic unused_field_odd_s;
  assign unused_field_odd_s = field_odd_q;
`endif

endmodule

// File: tb/tb_video_mode_detect.sv
// -----------------------------------------------------------------------------
// tb_video_mode_detect
//   Directed-vector bench for video_mode_detect. Lines are 2-clock hsync
//   pulses; each vsync pulse is followed by a settle period long enough for
//   the synchronizer latency. Expected values are hand-computed per step.
// -----------------------------------------------------------------------------
module tb_video_mode_detect;

  logic        clock;
  logic        reset_n;
  logic        hsync_n;
  logic        vsync_n;
  logic        active_n;
  logic        locked;
  logic        mode_changed;
  logic [10:0] line_count;
`ifdef VMD_FIELD_PARITY_EN
  logic        field_odd;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int mc_count = 0;
  int mc_base  = 0;

  video_mode_detect dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .hsync_n        (hsync_n),
    .vsync_n        (vsync_n),
    ._480p_active_n (active_n),
    .locked         (locked),
    .mode_changed   (mode_changed),
    .line_count     (line_count)
`ifdef VMD_FIELD_PARITY_EN
    ,
    .field_odd      (field_odd)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count mode_changed cycles, sampled on the inactive edge.
  always @(negedge clock) begin
    if (mode_changed) mc_count <= mc_count + 1;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic hline();
    @(negedge clock) hsync_n = 1'b0;
    @(negedge clock) hsync_n = 1'b1;
  endtask

  task automatic vpulse();
    @(negedge clock) vsync_n = 1'b0;
    @(negedge clock) vsync_n = 1'b1;
    settle(4);
  endtask

  task automatic frame(input int n);
    repeat (n) hline();
    vpulse();
  endtask

  initial begin
    reset_n = 1'b0;
    hsync_n = 1'b1;
    vsync_n = 1'b1;
    settle(3);
    check_val("rst_active_n", active_n, 1);
    check_val("rst_locked", locked, 0);
    check_val("rst_mode_changed", mode_changed, 0);
    check_val("rst_line_count", line_count, 0);
    reset_n = 1'b1;
    settle(2);

    // Lock onto 480p: one SEARCH vsync plus three 525-line measurements.
    vpulse();
    check_val("search_lc", line_count, 0);
    check_val("search_locked", locked, 0);
    mc_base = mc_count;
    frame(525);
    check_val("p1_lc", line_count, 525);
    check_val("p1_active_n", active_n, 1);
    check_val("p1_locked", locked, 0);
    frame(525);
    check_val("p2_active_n", active_n, 1);
    frame(525);
    check_val("p3_active_n", active_n, 0);
    check_val("p3_locked", locked, 1);
    check_val("p3_lc", line_count, 525);
    check_val("p3_pulse_cycles", mc_count - mc_base, 1);
    frame(525);
    check_val("p4_locked", locked, 1);
    check_val("p4_active_n", active_n, 0);

    // Two short glitch fields while locked at 480p.
    mc_base = mc_count;
    frame(262);
    check_val("g1_locked", locked, 0);
    check_val("g1_active_n", active_n, 0);
    check_val("g1_lc", line_count, 262);
    frame(262);
    check_val("g2_active_n", active_n, 0);
    frame(525);
    frame(525);
    check_val("g4_locked", locked, 0);
    frame(525);
    check_val("g5_locked", locked, 1);
    check_val("g5_active_n", active_n, 0);
    check_val("g_pulses", mc_count - mc_base, 0);

    // Switch to 480i with alternating 262/263 fields.
    mc_base = mc_count;
    frame(262);
`ifdef VMD_FIELD_PARITY_EN
    check_val("i1_field_odd", field_odd, 0);
`endif
    check_val("i1_active_n", active_n, 0);
    frame(263);
`ifdef VMD_FIELD_PARITY_EN
    check_val("i2_field_odd", field_odd, 1);
`endif
    check_val("i2_lc", line_count, 263);
    frame(262);
    check_val("i3_active_n", active_n, 1);
    check_val("i3_locked", locked, 1);
    check_val("i3_pulse_cycles", mc_count - mc_base, 1);
`ifdef VMD_FIELD_PARITY_EN
    check_val("i3_field_odd", field_odd, 0);
`endif

    // Back to 480p, then lose vsync.
    frame(525);
    frame(525);
    frame(525);
`ifdef VMD_FIELD_PARITY_EN
    check_val("r3_field_odd", field_odd, 0);
`endif
    check_val("r3_active_n", active_n, 0);
    check_val("r3_locked", locked, 1);
    mc_base = mc_count;
    repeat (2046) hline();
    settle(4);
    check_val("loss_2046_locked", locked, 1);
    hline();
    settle(4);
    check_val("loss_2047_locked", locked, 0);
    check_val("loss_active_n", active_n, 0);
    check_val("loss_lc", line_count, 525);
    repeat (10) hline();
    vpulse();
    check_val("resume_search_lc", line_count, 525);
    check_val("resume_search_locked", locked, 0);
    frame(525);
    frame(525);
    check_val("resume2_locked", locked, 0);
    frame(525);
    check_val("resume3_locked", locked, 1);
    check_val("resume_active_n", active_n, 0);
    check_val("loss_pulses", mc_count - mc_base, 0);

    // Coincident hsync and vsync edges.
    repeat (525) hline();
    @(negedge clock);
    hsync_n = 1'b0;
    vsync_n = 1'b0;
    @(negedge clock);
    hsync_n = 1'b1;
    vsync_n = 1'b1;
    settle(4);
    check_val("coinc_lc", line_count, 525);
    check_val("coinc_locked", locked, 1);
    frame(524);
    check_val("after_coinc_lc", line_count, 525);
    check_val("after_coinc_active_n", active_n, 0);

    // Reset mid-frame acts without a clock edge.
    repeat (100) hline();
    #2 reset_n = 1'b0;
    #1;
    check_val("midrst_active_n", active_n, 1);
    check_val("midrst_locked", locked, 0);
    check_val("midrst_mode_changed", mode_changed, 0);
    check_val("midrst_lc", line_count, 0);
    @(negedge clock) reset_n = 1'b1;
    frame(525);
    check_val("postrst_search_lc", line_count, 0);
    check_val("postrst_search_locked", locked, 0);
    frame(525);
    check_val("postrst_lc", line_count, 525);
    check_val("postrst_active_n", active_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_mode_detect.md
Name: video_mode_detect

Overview:
- Measures Dreamcast input video timing and produces `_480p_active_n`, the mode select consumed by the clock/line-doubler configuration logic.
- Counts hsync edges between successive vsync edges and classifies each frame or field as 480p (525 lines) or 480i (262/263 lines).
- Applies hysteresis before switching the mode output.
- Sits between the raw DC sync inputs and the configuration block, in the DC pixel clock domain.

Parameters:
- LINE_THRESHOLD, 400: measured line count >= this value classifies as progressive.
- STABLE_FRAMES, 3: consecutive agreeing measurements required before the mode output changes (range 1..7).
- LINE_MAX, 2047: line counter saturation value; reaching it means signal lost.
- CNT_W, 11: width of the line counter and `line_count`; must hold LINE_MAX.

Ports:
- clock  in  1  DC pixel clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- hsync_n  in  1  raw horizontal sync, active low, asynchronous to `clock`.
- vsync_n  in  1  raw vertical sync, active low, asynchronous to `clock`.
- _480p_active_n  out  1  0 = 480p active, 1 = 480i active.
- locked  out  1  1 = last STABLE_FRAMES measurements agree with the current mode.
- mode_changed  out  1  one-cycle pulse when `_480p_active_n` toggles.
- line_count  out  CNT_W  line count of the last completed frame or field.

Behaviour:
- Reset (async assert, sync release). Outputs: `_480p_active_n`=1, `locked`=0, `mode_changed`=0, `line_count`=0. Internals: state=SEARCH, counter=0, candidate=480i, agree=0, synchronizers=1.
- Input sync. Each sync input passes through a 2-flop synchronizer plus one delay flop. A falling edge is detected as delayed=1 and synced=0. Edge-to-output latency is 3 clocks from the clock edge that first samples the input low.
- State SEARCH.
  - hsync edges are ignored.
  - The first vsync edge clears the counter and moves the block to MEASURE. No classification is made (partial frame).
- State MEASURE.
  - Each hsync edge increments the counter.
  - On a vsync edge:
    - `line_count` takes the counter value.
    - The counter clears.
    - The frame is classified: prog = (counter >= LINE_THRESHOLD).
    - If prog equals candidate, agree increments, saturating at STABLE_FRAMES. Otherwise candidate takes prog and agree=1.
- Mode switch. When agree (post-update) reaches STABLE_FRAMES and candidate differs from the current mode, the following happen in the same cycle:
  - `_480p_active_n` takes !candidate.
  - `mode_changed`=1 for exactly one cycle.
- `locked` is registered: locked = (agree == STABLE_FRAMES) and (candidate == current mode). A disagreeing frame deasserts it on that same update.
- Simultaneous hsync and vsync edges in one cycle: vsync processing wins. The captured count excludes that hsync, and the counter restarts at 1 instead of 0.
- Signal loss. If the counter reaches LINE_MAX in MEASURE:
  - The counter holds at LINE_MAX.
  - locked=0, agree=0, state returns to SEARCH.
  - `_480p_active_n` and `line_count` hold their values.
- No vsync at all: the block stays in SEARCH. Outputs hold, apart from `locked`, which is 0.
- Reset mid-frame: all state is discarded immediately. After release, SEARCH requires a fresh vsync edge.

Optional Feature:
- Macro: VMD_FIELD_PARITY_EN.
- Defined:
  - Adds output `field_odd` (1 bit, reset 0).
  - On each vsync edge classified as 480i, `field_odd` takes 1 if the captured count is odd (263), else 0.
  - On a 480p frame, `field_odd` takes 0.
  - It updates in the same cycle as `line_count`.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset → `_480p_active_n`=1, `locked`=0, `mode_changed`=0, `line_count`=0. Assert `reset_n` mid-frame → the same values immediately, with no clock required.
- 5 vsync edges with 525 hsyncs per frame → after the 4th vsync edge (3rd measurement):
  - `_480p_active_n` 1→0.
  - `mode_changed` high exactly 1 cycle.
  - `locked`=1, `line_count`=525.
- After lock at 480p, alternate fields of 262 and 263 lines → after the 3rd field, `_480p_active_n`=1 with one `mode_changed` pulse. With VMD_FIELD_PARITY_EN, `field_odd` follows 0/1 per field.
- Locked at 480p, insert 2 fields of 262 lines, then resume 525:
  - `_480p_active_n` stays 0 with no pulse.
  - `locked`=0 from the first 262 capture.
  - `locked` re-asserts after 3 further 525-line frames.
- Stop vsync while hsync continues → after 2047 hsyncs from the last vsync, `locked`=0 and `_480p_active_n` holds. Resume 525-line frames → re-lock only after 1 SEARCH vsync plus 3 measurements.
- hsync and vsync falling edges in the same clock at 525 lines → the next captured `line_count`=525 (not 526 or 524), and classification is unchanged.
